memory_bus_target: RTL and testbench

// - Memory-side endpoint of the memory bus: takes request packets from the bus request slot,

---
 rtl/memory_bus_target.sv | 144 ++++++++++++++
 tb/tb_memory_bus_target.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_target.sv
// Memory-side bus endpoint: accepts one request packet at a time, executes it against an
// on-chip word RAM after a programmable latency, and posts read responses to the response slot.
module memory_bus_target #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int SOURCE_WIDTH  = 4,
  parameter int DEPTH_LOG2    = 10,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_busy,
  input  logic [1:0]              req_kind,
  input  logic [SOURCE_WIDTH-1:0] req_source,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_payload,
  output logic                    req_accept,
  input  logic                    resp_busy,
  output logic                    resp_send,
  output logic [1:0]              resp_kind,
  output logic [SOURCE_WIDTH-1:0] resp_source,
  output logic [ADDR_WIDTH-1:0]   resp_addr,
  output logic [DATA_WIDTH-1:0]   resp_payload,
  output logic                    idle,
  output logic                    err_pulse
);

  typedef enum logic [1:0] {
    KIND_READ  = 2'd0,
    KIND_WRITE = 2'd1,
    KIND_RESP  = 2'd2,
    KIND_RSVD  = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESPOND
  } state_e;

  localparam logic [3:0] READ_LAT  = 4'(READ_LATENCY);
  localparam logic [3:0] WRITE_LAT = 4'(WRITE_LATENCY);

  state_e                  r_state;
  logic [3:0]              r_count;
  kind_e                   r_kind;
  logic [SOURCE_WIDTH-1:0] r_source;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic [1:0]              r_resp_kind;
  logic [SOURCE_WIDTH-1:0] r_resp_source;
  logic [DATA_WIDTH-1:0]   r_resp_payload;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_mem [2**DEPTH_LOG2];

  logic                    w_in_range;
  logic [DEPTH_LOG2-1:0]   w_index;
  kind_e                   w_kind;
  logic                    w_accept;
  logic                    w_bad;
  logic                    w_exec_done;

  assign w_in_range = (req_addr[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
  assign w_index    = req_addr[DEPTH_LOG2-1:0];
  assign w_kind     = kind_e'(req_kind);
  // Accept is combinational so the bus can clear its slot on the very edge we latch the packet.
  assign w_accept   = (r_state == S_IDLE) && req_busy && !reset;
  assign w_bad      = (w_kind == KIND_RESP) || (w_kind == KIND_RSVD) || !w_in_range;

  always_comb begin
    w_exec_done = 1'b1;
    case (r_kind)
      KIND_READ:  w_exec_done = (r_count == READ_LAT);
      KIND_WRITE: w_exec_done = (r_count == WRITE_LAT);
      default:    w_exec_done = 1'b1;
    endcase
  end

  // NOTE: the RAM array has no reset; clearing it is not required and would block RAM inference.
  always_ff @(posedge clk) begin
    if (w_accept && (w_kind == KIND_WRITE) && w_in_range) begin
      r_mem[w_index] <= req_payload;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_kind         <= KIND_READ;
      r_source       <= '0;
      r_rd_data      <= '0;
      r_resp_kind    <= '0;
      r_resp_source  <= '0;
      r_resp_payload <= '0;
      r_err          <= 1'b0;
    end else begin
      r_err <= w_accept && w_bad;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_kind   <= w_kind;
            r_source <= req_source;
            r_count  <= 4'd1;
            if (w_kind == KIND_READ) begin
              r_rd_data <= w_in_range ? r_mem[w_index] : '0;
            end
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_exec_done) begin
            if (r_kind == KIND_READ) begin
              r_resp_kind    <= KIND_RESP;
              r_resp_source  <= r_source;
              r_resp_payload <= r_rd_data;
              r_state        <= S_RESPOND;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (r_count != 4'hF) begin
            r_count <= r_count + 4'd1;
          end
        end
        S_RESPOND: begin
          if (!resp_busy) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_accept   = w_accept;
  assign resp_send    = (r_state == S_RESPOND) && !resp_busy;
  assign resp_kind    = r_resp_kind;
  assign resp_source  = r_resp_source;
  assign resp_addr    = '0;
  assign resp_payload = r_resp_payload;
  assign idle         = (r_state == S_IDLE);
  assign err_pulse    = r_err;

endmodule

// File: tb/tb_memory_bus_target.sv
// Bench for memory_bus_target: directed scenarios plus randomized transactions checked against
// a word-array model with latency rules computed per packet kind.
module tb_memory_bus_target;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 4;
  localparam int DL = 10;
  localparam int RL = 2;
  localparam int WL = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_busy;
  logic [1:0]    req_kind;
  logic [SW-1:0] req_source;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_payload;
  logic          req_accept;
  logic          resp_busy;
  logic          resp_send;
  logic [1:0]    resp_kind;
  logic [SW-1:0] resp_source;
  logic [AW-1:0] resp_addr;
  logic [DW-1:0] resp_payload;
  logic          idle;
  logic          err_pulse;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem_model [int];

  memory_bus_target #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SOURCE_WIDTH(SW),
    .DEPTH_LOG2(DL), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .reset(reset),
    .req_busy(req_busy), .req_kind(req_kind), .req_source(req_source),
    .req_addr(req_addr), .req_payload(req_payload), .req_accept(req_accept),
    .resp_busy(resp_busy), .resp_send(resp_send), .resp_kind(resp_kind),
    .resp_source(resp_source), .resp_addr(resp_addr), .resp_payload(resp_payload),
    .idle(idle), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction; inputs change on the falling edge, outputs are sampled 1ns later.
  task automatic txn(input logic [1:0] kind, input logic [SW-1:0] src, input logic [AW-1:0] addr,
                     input logic [DW-1:0] pl, input int stall);
    bit            in_rng;
    bit            exp_err;
    int            lat;
    int            bad;
    logic [DW-1:0] exp_data;
    in_rng   = (addr[AW-1:DL] == '0);
    exp_err  = (kind >= 2'd2) || !in_rng;
    lat      = (kind == 2'd0) ? RL : (kind == 2'd1) ? WL : 1;
    exp_data = '0;
    if (kind == 2'd0 && in_rng) exp_data = mem_model[int'(addr[DL-1:0])];
    if (kind == 2'd1 && in_rng) mem_model[int'(addr[DL-1:0])] = pl;
    bad = 0;

    @(negedge clk);
    check("idle_before", idle, 1);
    req_kind = kind; req_source = src; req_addr = addr; req_payload = pl;
    req_busy = 1'b1;
    resp_busy = (stall > 0);
    #1 check("accept", req_accept, 1);
    @(negedge clk);
    req_busy = 1'b0;
    #1;
    check("err_pulse", err_pulse, exp_err);
    check("busy_after_accept", idle, 0);
    for (int n = 2; n <= lat; n++) begin
      @(negedge clk); #1;
      if (n == 2) check("err_single", err_pulse, 0);
      bad += int'(resp_send) + int'(idle);
    end
    check("exec_window", bad, 0);
    @(negedge clk); #1;
    if (lat == 1) check("err_single", err_pulse, 0);
    if (kind != 2'd0) begin
      check("idle_return", idle, 1);
      check("no_resp", resp_send, 0);
    end else begin
      check("respond_state", idle, 0);
      for (int s = 0; s < stall; s++) begin
        if (s > 0) begin @(negedge clk); #1; end
        check("stall_send", resp_send, 0);
        check("stall_payload", resp_payload, exp_data);
        check("stall_source", resp_source, src);
      end
      if (stall > 0) begin
        @(negedge clk); resp_busy = 1'b0; #1;
      end
      check("resp_send", resp_send, 1);
      check("resp_kind", resp_kind, 2);
      check("resp_source", resp_source, src);
      check("resp_addr", resp_addr, 0);
      check("resp_payload", resp_payload, exp_data);
      @(negedge clk); #1;
      check("resp_done_idle", idle, 1);
      check("resp_single", resp_send, 0);
      check("resp_hold", resp_payload, exp_data);
    end
  endtask

  initial begin
    int bad;
    logic [1:0]    k;
    logic [AW-1:0] a;
    reset = 1'b0; req_busy = 1'b0; resp_busy = 1'b0;
    req_kind = '0; req_source = '0; req_addr = '0; req_payload = '0;
    #1 reset = 1'b1;
    #2;
    check("rst_idle", idle, 1);
    check("rst_accept", req_accept, 0);
    check("rst_send", resp_send, 0);
    check("rst_err", err_pulse, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Prefill the address pool used by later reads.
    for (int i = 0; i < 16; i++) txn(2'd1, '0, AW'(i), {$urandom, $urandom}, 0);

    // Write then read back at address 5.
    txn(2'd1, 4'd0, 32'd5, 64'hDEAD_BEEF_0000_0001, 0);
    txn(2'd0, 4'd3, 32'd5, '0, 0);

    // Reset in the middle of a read's execution.
    @(negedge clk);
    req_kind = 2'd0; req_source = 4'd7; req_addr = 32'd5; req_busy = 1'b1;
    @(negedge clk);
    req_busy = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("mid_rst_idle", idle, 1);
    check("mid_rst_accept", req_accept, 0);
    check("mid_rst_send", resp_send, 0);
    check("mid_rst_kind", resp_kind, 0);
    check("mid_rst_source", resp_source, 0);
    check("mid_rst_addr", resp_addr, 0);
    check("mid_rst_payload", resp_payload, 0);
    check("mid_rst_err", err_pulse, 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      bad += int'(resp_send) + int'(!idle);
    end
    check("post_rst_quiet", bad, 0);

    // Response slot held busy for 7 cycles.
    txn(2'd0, 4'd9, 32'd5, '0, 7);

    // Out-of-range accesses alias nothing.
    txn(2'd1, 4'd0, 32'd0, 64'h0123_4567_89AB_CDEF, 0);
    txn(2'd0, 4'd2, 32'h400, '0, 0);
    txn(2'd1, 4'd0, 32'h400, 64'hFFFF_0000_FFFF_0000, 0);
    txn(2'd0, 4'd1, 32'd0, '0, 0);

    // Illegal request kinds.
    txn(2'd2, 4'd4, 32'd3, 64'h1, 0);
    txn(2'd3, 4'd5, 32'd3, 64'h2, 0);

    // Back-to-back writes with the request slot kept full.
    @(negedge clk);
    req_kind = 2'd1; req_source = 4'd0; req_addr = 32'd20; req_payload = 64'hAAAA_0000_0000_0014;
    req_busy = 1'b1;
    #1 check("b2b_first", req_accept, 1);
    mem_model[20] = 64'hAAAA_0000_0000_0014;
    @(negedge clk);
    req_addr = 32'd21; req_payload = 64'hBBBB_0000_0000_0015;
    #1 check("b2b_gap", req_accept, 0);
    @(negedge clk); #1;
    check("b2b_second", req_accept, 1);
    mem_model[21] = 64'hBBBB_0000_0000_0015;
    @(negedge clk);
    req_busy = 1'b0;
    @(negedge clk); #1;
    check("b2b_idle", idle, 1);
    txn(2'd0, 4'd6, 32'd20, '0, 0);
    txn(2'd0, 4'd8, 32'd21, '0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       k = 2'(2 + $urandom_range(0, 1));
        1, 2, 3: k = 2'd1;
        default: k = 2'd0;
      endcase
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h400;
      else                           a = AW'($urandom_range(0, 15));
      txn(k, SW'($urandom), a, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
